pkt_tx_fsm: RTL and testbench

Packet transmitter that drives the valid/head/tail word-stream framing consumed by the packet-receive FSM. It buffers payload words in a small FIFO. On a start request it emits a head beat carrying the length, then the payload words, then a tail beat. Its one-hot state register is exported so FSM coverage can sample it directly.

---
 rtl/pkt_tx_fsm.sv | 177 +++++++++++++++++
 tb/tb_pkt_tx_fsm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tx_fsm.sv
// pkt_tx_fsm: packet transmitter with a payload FIFO.
// Frames each packet as a head beat (length), the payload words and a tail beat.
// Optional feature: define PKT_TX_CHECKSUM_EN to put the XOR checksum of the header
// and payload words on the tail beat. Without it, the tail beat carries 0.
// Handshake: a start request is accepted on a clock edge where start=1 and
// start_ready=1. Payload pushes are accepted on a clock edge where wr_en=1 and
// full=0. There is no downstream backpressure, so each valid beat is transferred
// in the cycle it is presented.
module pkt_tx_fsm #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  output logic                     start_ready,
  output logic                     valid,
  output logic                     head,
  output logic                     tail,
  output logic [DATA_W-1:0]        data,
  output logic [15:0]              state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [15:0] {
    S_IDLE = 16'h0001,
    S_HEAD = 16'h0010,
    S_DATA = 16'h0100,
    S_TAIL = 16'h1000
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              full_q, overflow_q;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              valid_q, valid_d, head_q, head_d, tail_q, tail_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push, pop, ready_w;
  logic [DATA_W-1:0] hdr_word, rd_word, tail_word;

  // A push is judged against the registered full flag, so a same-cycle pop
  // cannot make room for it.
  assign push     = wr_en & ~full_q;
  assign hdr_word = DATA_W'(len);
  assign rd_word  = mem_q[rd_ptr_q];
  assign ready_w  = (state_q == S_IDLE) || (state_q == S_TAIL);

`ifdef PKT_TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  // Checksum: seeded with the header on acceptance, folds in each popped word.
  always_comb begin
    csum_d = csum_q;
    if (start && ready_w) csum_d = hdr_word;
    else if (pop)         csum_d = csum_q ^ rd_word;
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign tail_word = csum_q;
`else
  assign tail_word = '0;
`endif

  // Next-state and next-beat logic. rem_q counts payload words still to be
  // popped. The pop for a data beat happens on the edge that presents that beat.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    head_d  = 1'b0;
    tail_d  = 1'b0;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE, S_TAIL: begin
        if (start) begin
          state_d = S_HEAD;
          rem_d   = len;
          valid_d = 1'b1;
          head_d  = 1'b1;
          data_d  = hdr_word;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HEAD, S_DATA: begin
        if (rem_q == '0) begin
          state_d = S_TAIL;
          valid_d = 1'b1;
          tail_d  = 1'b1;
          data_d  = tail_word;
        end else begin
          state_d = S_DATA;
          // An empty FIFO leaves an underrun gap: valid stays low and data holds.
          if (count_q != '0) begin
            pop     = 1'b1;
            rem_d   = rem_q - LEN_W'(1);
            valid_d = 1'b1;
            data_d  = rd_word;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy update.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State, beat outputs, FIFO pointers and flags. Reset also flushes the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      valid_q    <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      data_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      data_q   <= data_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && full_q) overflow_q <= 1'b1;
    end
  end

  // Payload storage; contents need no reset because the pointers do.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full        = full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign start_ready = ready_w;
  assign valid       = valid_q;
  assign head        = head_q;
  assign tail        = tail_q;
  assign data        = data_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pkt_tx_fsm.sv
// Testbench for pkt_tx_fsm: directed framing/timing scenarios plus randomized
// packets checked against a packet-level reference model (expected beat queue).
module tb_pkt_tx_fsm;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 16;
`ifdef PKT_TX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic [4:0]        count;
  logic              overflow;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              start_ready;
  logic              valid;
  logic              head;
  logic              tail;
  logic [DATA_W-1:0] data;
  logic [15:0]       state;

  // Expected beats, encoded {head, tail, data}.
  logic [DATA_W+1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  pkt_tx_fsm #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .count(count), .overflow(overflow), .start(start), .len(len),
    .start_ready(start_ready), .valid(valid), .head(head), .tail(tail),
    .data(data), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: tail value of a packet from its header and payload.
  function automatic logic [DATA_W-1:0] tail_of(input logic [DATA_W-1:0] hdr,
                                                 input logic [DATA_W-1:0] w[$]);
    logic [DATA_W-1:0] x;
    x = hdr;
    foreach (w[i]) x = x ^ w[i];
    return CSUM_EN ? x : '0;
  endfunction

  // Reference model: a packet of L words is head(L), the words in order, tail.
  task automatic expect_packet(input int l, input logic [DATA_W-1:0] w[$]);
    exp_q.push_back({2'b10, DATA_W'(l)});
    foreach (w[i]) exp_q.push_back({2'b00, w[i]});
    exp_q.push_back({2'b01, tail_of(DATA_W'(l), w)});
  endtask

  // Scoreboard: every valid beat outside reset must be the next expected one.
  always @(negedge clk) begin
    if (!reset && valid) begin
      if (exp_q.size() == 0) check("unexpected_beat", 32'(exp_q.size()), 32'd1);
      else                   check("beat", 32'({head, tail, data}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic chk_cyc(input string tag, input logic [15:0] st, input logic v);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_valid"}, 32'(valid), 32'(v));
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] wq[$];
  logic [DATA_W-1:0] w1, w2;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; len = '0;

    // Reset held for two cycles.
    tick(); tick();
    chk_cyc("rst", 16'h0001, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    reset = 1'b0;
    tick();

    // Normal packet of three pre-queued words.
    wq.delete();
    wq.push_back(16'h00A1); wq.push_back(16'h00B2); wq.push_back(16'h00C3);
    foreach (wq[i]) push_word(wq[i]);
    check("t2_count", 32'(count), 32'd3);
    start = 1'b1; len = 8'd3;
    expect_packet(3, wq);
    tick();
    start = 1'b0;
    chk_cyc("t2_head", 16'h0010, 1'b1);
    check("t2_head_flag", 32'(head), 32'd1);
    check("t2_head_data", 32'(data), 32'h0003);
    check("t2_head_ready", 32'(start_ready), 32'd0);
    tick(); chk_cyc("t2_d0", 16'h0100, 1'b1); check("t2_d0_data", 32'(data), 32'h00A1);
    tick(); chk_cyc("t2_d1", 16'h0100, 1'b1); check("t2_d1_data", 32'(data), 32'h00B2);
    tick(); chk_cyc("t2_d2", 16'h0100, 1'b1); check("t2_d2_data", 32'(data), 32'h00C3);
    check("t2_count_end", 32'(count), 32'd0);
    tick(); chk_cyc("t2_tail", 16'h1000, 1'b1);
    check("t2_tail_flag", 32'(tail), 32'd1);
    check("t2_tail_data", 32'(data), CSUM_EN ? 32'h00D3 : 32'h0);
    tick(); chk_cyc("t2_idle", 16'h0001, 1'b0);

    // Zero-length packet.
    start = 1'b1; len = 8'd0;
    wq.delete();
    expect_packet(0, wq);
    tick(); start = 1'b0;
    chk_cyc("t3_head", 16'h0010, 1'b1); check("t3_head_data", 32'(data), 32'h0);
    tick(); chk_cyc("t3_tail", 16'h1000, 1'b1); check("t3_tail_data", 32'(data), 32'h0);
    tick(); chk_cyc("t3_idle", 16'h0001, 1'b0);
    check("t3_count", 32'(count), 32'd0);

    // Underrun: one word queued for a two-word packet.
    wq.delete(); wq.push_back(16'h1111); wq.push_back(16'h2222);
    push_word(16'h1111);
    start = 1'b1; len = 8'd2;
    expect_packet(2, wq);
    tick(); start = 1'b0;
    chk_cyc("t4_head", 16'h0010, 1'b1);
    tick(); chk_cyc("t4_d0", 16'h0100, 1'b1); check("t4_d0_data", 32'(data), 32'h1111);
    tick(); chk_cyc("t4_gap0", 16'h0100, 1'b0); check("t4_gap0_data", 32'(data), 32'h1111);
    tick(); chk_cyc("t4_gap1", 16'h0100, 1'b0);
    wr_en = 1'b1; wr_data = 16'h2222;
    tick(); wr_en = 1'b0;
    chk_cyc("t4_gap2", 16'h0100, 1'b0);
    check("t4_gap2_head", 32'(head | tail), 32'd0);
    tick(); chk_cyc("t4_d1", 16'h0100, 1'b1); check("t4_d1_data", 32'(data), 32'h2222);
    tick(); chk_cyc("t4_tail", 16'h1000, 1'b1);
    check("t4_tail_data", 32'(data), CSUM_EN ? 32'h3331 : 32'h0);
    tick(); chk_cyc("t4_idle", 16'h0001, 1'b0);

    // Back-to-back packets with start held high.
    w1 = 16'($urandom); w2 = 16'($urandom);
    push_word(w1); push_word(w2);
    start = 1'b1; len = 8'd1;
    wq.delete(); wq.push_back(w1); expect_packet(1, wq);
    wq.delete(); wq.push_back(w2); expect_packet(1, wq);
    tick(); chk_cyc("t5_head1", 16'h0010, 1'b1);
    tick(); chk_cyc("t5_d1", 16'h0100, 1'b1);
    tick(); chk_cyc("t5_tail1", 16'h1000, 1'b1);
    tick(); chk_cyc("t5_head2", 16'h0010, 1'b1); check("t5_head2_flag", 32'(head), 32'd1);
    start = 1'b0;
    tick(); chk_cyc("t5_d2", 16'h0100, 1'b1); check("t5_d2_data", 32'(data), 32'(w2));
    tick(); chk_cyc("t5_tail2", 16'h1000, 1'b1);
    tick(); chk_cyc("t5_idle", 16'h0001, 1'b0);

    // Overflow, then reset mid-packet.
    wq.delete();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        check("t6_full16", 32'(full), 32'd1);
        check("t6_ovf_before", 32'(overflow), 32'd0);
      end
      w1 = 16'($urandom);
      if (i < 16) wq.push_back(w1);
      push_word(w1);
    end
    check("t6_full", 32'(full), 32'd1);
    check("t6_count", 32'(count), 32'd16);
    check("t6_overflow", 32'(overflow), 32'd1);
    start = 1'b1; len = 8'd16;
    expect_packet(16, wq);
    tick(); start = 1'b0;
    chk_cyc("t6_head", 16'h0010, 1'b1);
    tick(); chk_cyc("t6_d0", 16'h0100, 1'b1); check("t6_d0_data", 32'(data), 32'(wq[0]));
    tick(); chk_cyc("t6_d1", 16'h0100, 1'b1);
    reset = 1'b1;
    tick();
    chk_cyc("t6_abort", 16'h0001, 1'b0);
    check("t6_abort_count", 32'(count), 32'd0);
    check("t6_abort_full", 32'(full), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    tick();

    // Randomized packets with random pre-fill and underrun gaps.
    for (int p = 0; p < 24; p++) begin
      int l, pre, n;
      l   = $urandom_range(0, 6);
      pre = $urandom_range(0, l);
      wq.delete();
      for (int i = 0; i < l; i++) wq.push_back(16'($urandom));
      for (int i = 0; i < pre; i++) push_word(wq[i]);
      start = 1'b1; len = LEN_W'(l);
      expect_packet(l, wq);
      tick(); start = 1'b0;
      for (int i = pre; i < l; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        push_word(wq[i]);
      end
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        tick();
        n++;
      end
      check("rnd_drain", 32'(exp_q.size()), 32'd0);
      chk_cyc("rnd_idle", 16'h0001, 1'b0);
      check("rnd_count", 32'(count), 32'd0);
      check("rnd_overflow", 32'(overflow), 32'd0);
      repeat ($urandom_range(0, 2)) tick();
    end

    check("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
